// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax sequencer.
package softmax_pkg;

  // Datapath geometry of the FP vector arrays this sequencer drives.
  localparam int LANES        = 4;
  localparam int FP_W         = 32;

  localparam int DATA_NUM_DEF = 192;
  localparam int WAIT_MAX_DEF = 1023;
  localparam int ADDR_W_DEF   = 8;

  localparam int STATE_W      = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_MAX_RD   = 4'd1,
    S_MAX_WAIT = 4'd2,
    S_EXP_RD   = 4'd3,
    S_EXP_WAIT = 4'd4,
    S_REC      = 4'd5,
    S_MUL_RD   = 4'd6,
    S_MUL_WAIT = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  // States in which the watchdog counts.
  function automatic logic is_wait_state(state_t s);
    return (s == S_MAX_WAIT) || (s == S_EXP_WAIT) || (s == S_REC) || (s == S_MUL_WAIT);
  endfunction

endpackage

// File: rtl/softmax_seq_vld_dly.sv
// Delays the buffer read strobe by the buffer read latency so the pass
// valid lines line up with the data coming out of the beat buffer.
module vld_dly
  import softmax_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld
);

  logic [LAT-1:0] r_sr;

  generate
    if (LAT == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= i_vld;
      end
    end else begin : g_multi
      // LAT-stage shift register, oldest bit at the top.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= {r_sr[LAT-2:0], i_vld};
      end
    end
  endgenerate

  assign o_vld = r_sr[LAT-1];

endmodule

// File: rtl/softmax_seq.sv
// Softmax sequencer: walks the beat buffer three times (max, exp/sum,
// scale by 1/sum) and produces every strobe and address the FP arrays and
// the buffers need. No FP data passes through here.
//
// Handshake: every *_tvalid and *_rvalid is a one-cycle qualifier with no
// backpressure; a beat is transferred in each cycle its valid is high, and
// the receiving side must always be able to take it.
module softmax_seq
  import softmax_pkg::*;
#(
  parameter int DATA_NUM = DATA_NUM_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BUF_LAT  = 1,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              cmp_init,
  output logic              cmp_tvalid,
  input  logic              cmp_rvalid,
  output logic              exp_tvalid,
  input  logic              exp_rvalid,
  output logic              acc_tlast,
  input  logic              acc_rvalid,
  output logic              rec_tvalid,
  input  logic              rec_rvalid,
  output logic              mul_tvalid,
  input  logic              mul_rvalid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int CNT_W = $clog2(DATA_NUM + 1);
  localparam int WD_W  = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_NUM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_NUM);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WAIT_MAX - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_exp_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [WD_W-1:0]  r_wd_cnt;

  logic w_rd_phase;
  logic w_max_phase;
  logic w_exp_phase;
  logic w_mul_phase;
  logic w_wd_phase;
  logic w_last_rd;
  logic w_exp_take;
  logic w_wr_take;
  logic w_wd_expired;
  logic w_dly_vld;
  logic w_err;

  // Phase decode shared by the counters, the valid demux and the FSM.
  always_comb begin
    w_rd_phase   = (r_state == S_MAX_RD) || (r_state == S_EXP_RD) || (r_state == S_MUL_RD);
    w_max_phase  = (r_state == S_MAX_RD) || (r_state == S_MAX_WAIT);
    w_exp_phase  = (r_state == S_EXP_RD) || (r_state == S_EXP_WAIT);
    w_mul_phase  = (r_state == S_MUL_RD) || (r_state == S_MUL_WAIT);
    w_wd_phase   = is_wait_state(r_state);
    w_last_rd    = w_rd_phase && (r_rd_cnt == LAST_IDX);
    // Exp results start returning while the exp pass is still reading, so
    // they are counted in both halves of the pass.
    w_exp_take   = exp_rvalid && w_exp_phase && (r_exp_cnt != FULL_CNT);
    w_wr_take    = mul_rvalid && w_mul_phase && (r_wr_cnt != FULL_CNT);
    // Fires in the WAIT_MAX-th consecutive cycle spent in a wait state.
    w_wd_expired = w_wd_phase && (r_wd_cnt == WD_LAST);
  end

  vld_dly #(.LAT(BUF_LAT)) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_rd_phase),
    .o_vld (w_dly_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a result arriving in the expiry cycle still wins.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_MAX_RD;
      S_MAX_RD:   if (w_last_rd) w_state_nxt = S_MAX_WAIT;
      S_MAX_WAIT: begin
        if (cmp_rvalid)        w_state_nxt = S_EXP_RD;
        else if (w_wd_expired) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
      end
      S_EXP_RD:   if (w_last_rd) w_state_nxt = S_EXP_WAIT;
      S_EXP_WAIT: begin
        if (acc_rvalid)        w_state_nxt = S_REC;
        else if (w_wd_expired) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
      end
      S_REC: begin
        if (rec_rvalid)        w_state_nxt = S_MUL_RD;
        else if (w_wd_expired) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
      end
      S_MUL_RD:   if (w_last_rd) w_state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if ((w_wr_take && (r_wr_cnt == LAST_IDX)) || (r_wr_cnt == FULL_CNT))
          w_state_nxt = S_DONE;
        else if (w_wd_expired) begin w_state_nxt = S_IDLE; w_err = 1'b1; end
      end
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Read address counter: runs 0..DATA_NUM-1 within each read pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_rd_cnt <= '0;
    else if (!w_rd_phase)     r_rd_cnt <= '0;
    else if (w_last_rd)       r_rd_cnt <= '0;
    else                      r_rd_cnt <= r_rd_cnt + 1'b1;
  end

  // Exp result counter, used only to place acc_tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_exp_cnt <= '0;
    else if (!w_exp_phase)    r_exp_cnt <= '0;
    else if (w_exp_take)      r_exp_cnt <= r_exp_cnt + 1'b1;
  end

  // Output write address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_wr_cnt <= '0;
    else if (!w_mul_phase)    r_wr_cnt <= '0;
    else if (w_wr_take)       r_wr_cnt <= r_wr_cnt + 1'b1;
  end

  // Watchdog: counts cycles in a wait state, restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_wd_cnt <= '0;
    else if (!w_wd_phase || (w_state_nxt != r_state))  r_wd_cnt <= '0;
    else if (r_wd_cnt != WD_LAST)                      r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    err        = w_err;
    rd_en      = w_rd_phase;
    rd_addr    = w_rd_phase ? ADDR_W'(r_rd_cnt) : '0;
    cmp_init   = (r_state == S_MAX_RD) && (r_rd_cnt == '0);
    cmp_tvalid = w_dly_vld && w_max_phase;
    exp_tvalid = w_dly_vld && w_exp_phase;
    mul_tvalid = w_dly_vld && w_mul_phase;
    acc_tlast  = w_exp_take && (r_exp_cnt == LAST_IDX);
    rec_tvalid = (r_state == S_REC) && (r_wd_cnt == '0);
    wr_en      = w_wr_take;
    wr_addr    = w_wr_take ? ADDR_W'(r_wr_cnt) : '0;
    dbg_state  = r_state;
  end

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq with 3-cycle IP models on the main
// instance and a BUF_LAT=3 instance for the latency scenario.
module tb_softmax_seq;
  import softmax_pkg::*;

  localparam int DN = 4;
  localparam int AW = 8;
  localparam int WM = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic start = 1'b0;
  logic start_b = 1'b0;
  logic rec_hold = 1'b0;
  logic force_cmp = 1'b0;
  logic force_mul = 1'b0;

  // ---------------- main DUT ----------------
  logic busy, done, err, rd_en, cmp_init, cmp_tvalid, cmp_rvalid, exp_tvalid, exp_rvalid;
  logic acc_tlast, acc_rvalid, rec_tvalid, rec_rvalid, mul_tvalid, mul_rvalid, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0] dbg_state;

  softmax_seq #(.DATA_NUM(DN), .ADDR_W(AW), .BUF_LAT(1), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .cmp_init(cmp_init), .cmp_tvalid(cmp_tvalid),
    .cmp_rvalid(cmp_rvalid), .exp_tvalid(exp_tvalid), .exp_rvalid(exp_rvalid),
    .acc_tlast(acc_tlast), .acc_rvalid(acc_rvalid), .rec_tvalid(rec_tvalid),
    .rec_rvalid(rec_rvalid), .mul_tvalid(mul_tvalid), .mul_rvalid(mul_rvalid),
    .wr_en(wr_en), .wr_addr(wr_addr), .dbg_state(dbg_state)
  );

  // ---------------- BUF_LAT=3 DUT (no result models) ----------------
  logic busy_b, done_b, err_b, rd_en_b, cmp_init_b, cmp_tvalid_b, exp_tvalid_b;
  logic acc_tlast_b, rec_tvalid_b, mul_tvalid_b, wr_en_b;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [3:0] dbg_state_b;

  softmax_seq #(.DATA_NUM(DN), .ADDR_W(AW), .BUF_LAT(3), .WAIT_MAX(WM)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .cmp_init(cmp_init_b), .cmp_tvalid(cmp_tvalid_b),
    .cmp_rvalid(1'b0), .exp_tvalid(exp_tvalid_b), .exp_rvalid(1'b0),
    .acc_tlast(acc_tlast_b), .acc_rvalid(1'b0), .rec_tvalid(rec_tvalid_b),
    .rec_rvalid(1'b0), .mul_tvalid(mul_tvalid_b), .mul_rvalid(1'b0),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .dbg_state(dbg_state_b)
  );

  // ---------------- IP models, latency 3 ----------------
  logic [2:0] p_cmp, p_exp, p_acc, p_rec, p_mul;
  int cmp_beats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cmp <= '0; p_exp <= '0; p_acc <= '0; p_rec <= '0; p_mul <= '0;
      cmp_beats <= 0;
    end else begin
      p_cmp <= {p_cmp[1:0], cmp_tvalid && (cmp_beats == DN - 1)};
      p_exp <= {p_exp[1:0], exp_tvalid};
      p_acc <= {p_acc[1:0], acc_tlast};
      p_rec <= {p_rec[1:0], rec_tvalid && !rec_hold};
      p_mul <= {p_mul[1:0], mul_tvalid};
      if (cmp_init)        cmp_beats <= 0;
      else if (cmp_tvalid) cmp_beats <= (cmp_beats == DN - 1) ? 0 : cmp_beats + 1;
    end
  end

  assign cmp_rvalid = p_cmp[2] | force_cmp;
  assign exp_rvalid = p_exp[2];
  assign acc_rvalid = p_acc[2];
  assign rec_rvalid = p_rec[2];
  assign mul_rvalid = p_mul[2] | force_mul;

  // ---------------- monitor (negedge sampling) ----------------
  int cyc = 0;
  int rd_log[$];
  int wr_log[$];
  int n_init = 0, n_cmp = 0, n_exp = 0, n_mul = 0, n_tlast = 0, n_rec = 0, n_done = 0, n_err = 0;
  int init_cyc = 0, cmp_cyc = 0, rec_cyc = 0, err_cyc = 0, tlast_pos = 0, exp_run = 0;
  logic seen_cmp = 1'b0;
  int b_n_cmp = 0, b_n_rd = 0, b_n_err = 0, b_init_cyc = 0, b_cmp_cyc = 0;
  logic b_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rd_en) rd_log.push_back(int'(rd_addr));
    if (wr_en) wr_log.push_back(int'(wr_addr));
    if (cmp_init) begin n_init++; init_cyc = cyc; seen_cmp = 1'b0; exp_run = 0; end
    if (cmp_tvalid) begin
      n_cmp++;
      if (!seen_cmp) begin seen_cmp = 1'b1; cmp_cyc = cyc; end
    end
    if (exp_tvalid) n_exp++;
    if (mul_tvalid) n_mul++;
    if (exp_rvalid) exp_run++;
    if (acc_tlast) begin n_tlast++; tlast_pos = exp_run; end
    if (rec_tvalid) begin n_rec++; rec_cyc = cyc; end
    if (done) n_done++;
    if (err) begin n_err++; err_cyc = cyc; end
    if (cmp_init_b) begin b_init_cyc = cyc; b_seen = 1'b0; end
    if (cmp_tvalid_b) begin
      b_n_cmp++;
      if (!b_seen) begin b_seen = 1'b1; b_cmp_cyc = cyc; end
    end
    if (rd_en_b) b_n_rd++;
    if (err_b) b_n_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(done === 1'b1 || err === 1'b1) && k < 300) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s_end_timeout: waited %0d cycles, required done or err", name, k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    int k;
    k = 0;
    while (dbg_state !== s && k < 300) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL %s_state_timeout: state %0d, required %0d", name, dbg_state, s);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, rd_en, cmp_init, cmp_tvalid, exp_tvalid, acc_tlast, rec_tvalid,
         mul_tvalid, wr_en, rd_addr, wr_addr, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%0d/%0d/%0d, required all zero",
               {busy, done, err, rd_en, cmp_init, cmp_tvalid, exp_tvalid, acc_tlast,
                rec_tvalid, mul_tvalid, wr_en}, rd_addr, wr_addr, dbg_state);
    end
    checks++;
    if ({busy_b, done_b, err_b, rd_en_b, cmp_init_b, cmp_tvalid_b, exp_tvalid_b, acc_tlast_b,
         rec_tvalid_b, mul_tvalid_b, wr_en_b, rd_addr_b, wr_addr_b, dbg_state_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: dut_b outputs not all zero, state %0d", dbg_state_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int b_rd, b_wr, b_cmp, b_exp, b_mul, b_init, b_tl, b_done, b_err, b_rec;
    b_rd = rd_log.size(); b_wr = wr_log.size(); b_cmp = n_cmp; b_exp = n_exp; b_mul = n_mul;
    b_init = n_init; b_tl = n_tlast; b_done = n_done; b_err = n_err; b_rec = n_rec;
    pulse_start();
    wait_end("nominal");
    checks++;
    if (rd_log.size() - b_rd !== 3 * DN) begin
      errors++; $display("FAIL nominal_rd_count: got %0d, required %0d", rd_log.size() - b_rd, 3 * DN);
    end
    for (int i = 0; i < 3 * DN; i++) begin
      checks++;
      if (b_rd + i >= rd_log.size()) begin
        errors++; $display("FAIL nominal_rd_addr[%0d]: missing, required %0d", i, i % DN);
      end else if (rd_log[b_rd + i] !== i % DN) begin
        errors++; $display("FAIL nominal_rd_addr[%0d]: got %0d, required %0d", i, rd_log[b_rd + i], i % DN);
      end
    end
    for (int i = 0; i < DN; i++) begin
      checks++;
      if (b_wr + i >= wr_log.size()) begin
        errors++; $display("FAIL nominal_wr_addr[%0d]: missing, required %0d", i, i);
      end else if (wr_log[b_wr + i] !== i) begin
        errors++; $display("FAIL nominal_wr_addr[%0d]: got %0d, required %0d", i, wr_log[b_wr + i], i);
      end
    end
    checks++;
    if (wr_log.size() - b_wr !== DN) begin
      errors++; $display("FAIL nominal_wr_count: got %0d, required %0d", wr_log.size() - b_wr, DN);
    end
    checks++;
    if (n_cmp - b_cmp !== DN) begin errors++; $display("FAIL nominal_cmp_valids: got %0d, required %0d", n_cmp - b_cmp, DN); end
    checks++;
    if (n_exp - b_exp !== DN) begin errors++; $display("FAIL nominal_exp_valids: got %0d, required %0d", n_exp - b_exp, DN); end
    checks++;
    if (n_mul - b_mul !== DN) begin errors++; $display("FAIL nominal_mul_valids: got %0d, required %0d", n_mul - b_mul, DN); end
    checks++;
    if (n_init - b_init !== 1) begin errors++; $display("FAIL nominal_cmp_init: got %0d, required 1", n_init - b_init); end
    checks++;
    if (cmp_cyc - init_cyc !== 1) begin errors++; $display("FAIL nominal_cmp_lag: got %0d, required 1", cmp_cyc - init_cyc); end
    checks++;
    if (n_tlast - b_tl !== 1) begin errors++; $display("FAIL nominal_tlast_count: got %0d, required 1", n_tlast - b_tl); end
    checks++;
    if (tlast_pos !== DN) begin errors++; $display("FAIL nominal_tlast_pos: got %0d, required %0d", tlast_pos, DN); end
    checks++;
    if (n_rec - b_rec !== 1) begin errors++; $display("FAIL nominal_rec_valid: got %0d, required 1", n_rec - b_rec); end
    checks++;
    if (n_done - b_done !== 1) begin errors++; $display("FAIL nominal_done: got %0d, required 1", n_done - b_done); end
    checks++;
    if (n_err - b_err !== 0) begin errors++; $display("FAIL nominal_err: got %0d, required 0", n_err - b_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_busy_start();
    int b_rd, b_init, b_done;
    b_rd = rd_log.size(); b_init = n_init; b_done = n_done;
    pulse_start();
    wait_state(S_EXP_RD, "busy_start");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_end("busy_start");
    repeat (40) @(negedge clk);
    checks++;
    if (rd_log.size() - b_rd !== 3 * DN) begin
      errors++; $display("FAIL busy_start_rd_count: got %0d, required %0d", rd_log.size() - b_rd, 3 * DN);
    end
    for (int i = 0; i < 3 * DN; i++) begin
      checks++;
      if (b_rd + i >= rd_log.size()) begin
        errors++; $display("FAIL busy_start_rd_addr[%0d]: missing, required %0d", i, i % DN);
      end else if (rd_log[b_rd + i] !== i % DN) begin
        errors++; $display("FAIL busy_start_rd_addr[%0d]: got %0d, required %0d", i, rd_log[b_rd + i], i % DN);
      end
    end
    checks++;
    if (n_init - b_init !== 1) begin errors++; $display("FAIL busy_start_restart: got %0d inits, required 1", n_init - b_init); end
    checks++;
    if (n_done - b_done !== 1) begin errors++; $display("FAIL busy_start_done: got %0d, required 1", n_done - b_done); end
  endtask

  task automatic test_watchdog();
    int b_done, b_err;
    b_done = n_done; b_err = n_err;
    rec_hold = 1'b1;
    pulse_start();
    wait_end("watchdog");
    rec_hold = 1'b0;
    checks++;
    if (n_err - b_err !== 1) begin errors++; $display("FAIL watchdog_err_count: got %0d, required 1", n_err - b_err); end
    // err is high in the 16th cycle spent in REC: 15 cycles after entry.
    checks++;
    if (err_cyc - rec_cyc !== WM - 1) begin
      errors++; $display("FAIL watchdog_err_time: got %0d, required %0d", err_cyc - rec_cyc, WM - 1);
    end
    checks++;
    if (n_done - b_done !== 0) begin errors++; $display("FAIL watchdog_done: got %0d, required 0", n_done - b_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL watchdog_busy: got %b, required 0", busy); end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL watchdog_state: got %0d, required %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_reset_mid_pass();
    int k, b_rd, b_wr, b_done;
    pulse_start();
    k = 0;
    while (!(dbg_state === S_MUL_RD && rd_addr === 2) && k < 300) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 300) begin errors++; $display("FAIL reset_mid_wait: got state %0d, required MUL_RD at addr 2", dbg_state); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, rd_en, cmp_init, cmp_tvalid, exp_tvalid, acc_tlast, rec_tvalid,
         mul_tvalid, wr_en} !== '0) begin
      errors++;
      $display("FAIL reset_mid_strobes: got %b, required 0",
               {busy, done, err, rd_en, cmp_init, cmp_tvalid, exp_tvalid, acc_tlast,
                rec_tvalid, mul_tvalid, wr_en});
    end
    checks++;
    if ({rd_addr, wr_addr, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_mid_addr: rd %0d wr %0d state %0d, required 0", rd_addr, wr_addr, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b_rd = rd_log.size(); b_wr = wr_log.size(); b_done = n_done;
    pulse_start();
    wait_end("reset_mid");
    for (int i = 0; i < 3 * DN; i++) begin
      checks++;
      if (b_rd + i >= rd_log.size()) begin
        errors++; $display("FAIL reset_mid_rd_addr[%0d]: missing, required %0d", i, i % DN);
      end else if (rd_log[b_rd + i] !== i % DN) begin
        errors++; $display("FAIL reset_mid_rd_addr[%0d]: got %0d, required %0d", i, rd_log[b_rd + i], i % DN);
      end
    end
    for (int i = 0; i < DN; i++) begin
      checks++;
      if (b_wr + i >= wr_log.size()) begin
        errors++; $display("FAIL reset_mid_wr_addr[%0d]: missing, required %0d", i, i);
      end else if (wr_log[b_wr + i] !== i) begin
        errors++; $display("FAIL reset_mid_wr_addr[%0d]: got %0d, required %0d", i, wr_log[b_wr + i], i);
      end
    end
    checks++;
    if (n_done - b_done !== 1) begin errors++; $display("FAIL reset_mid_done: got %0d, required 1", n_done - b_done); end
  endtask

  task automatic test_stray_results();
    int b_wr, b_done;
    b_wr = wr_log.size(); b_done = n_done;
    pulse_start();
    wait_state(S_EXP_WAIT, "stray");
    force_cmp = 1'b1;
    @(negedge clk); force_cmp = 1'b0;
    checks++;
    if (dbg_state !== S_EXP_WAIT) begin
      errors++; $display("FAIL stray_cmp_state: got %0d, required %0d", dbg_state, S_EXP_WAIT);
    end
    wait_end("stray");
    force_mul = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL stray_mul_wr_en: got %b, required 0", wr_en); end
    force_mul = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_log.size() - b_wr !== DN) begin
      errors++; $display("FAIL stray_wr_count: got %0d, required %0d", wr_log.size() - b_wr, DN);
    end
    checks++;
    if (n_done - b_done !== 1) begin errors++; $display("FAIL stray_done: got %0d, required 1", n_done - b_done); end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL stray_state: got %0d, required %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_buf_latency();
    int b_cmp, b_rd, b_err;
    b_cmp = b_n_cmp; b_rd = b_n_rd; b_err = b_n_err;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (b_cmp_cyc - b_init_cyc !== 3) begin
      errors++; $display("FAIL lat3_first_cmp: got %0d cycles, required 3", b_cmp_cyc - b_init_cyc);
    end
    checks++;
    if (b_n_cmp - b_cmp !== DN) begin errors++; $display("FAIL lat3_cmp_count: got %0d, required %0d", b_n_cmp - b_cmp, DN); end
    checks++;
    if (b_n_rd - b_rd !== DN) begin errors++; $display("FAIL lat3_rd_count: got %0d, required %0d", b_n_rd - b_rd, DN); end
    // No compare result ever comes back, so MAX_WAIT times out.
    checks++;
    if (b_n_err - b_err !== 1) begin errors++; $display("FAIL lat3_err: got %0d, required 1", b_n_err - b_err); end
    checks++;
    if ({busy_b, done_b, dbg_state_b} !== '0) begin
      errors++; $display("FAIL lat3_idle: busy %b done %b state %0d, required idle", busy_b, done_b, dbg_state_b);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_busy_start();
    test_watchdog();
    test_reset_mid_pass();
    test_stray_results();
    test_buf_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
